// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM-to-RAM image loader.
package rom_loader_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LANE_W     = 2;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rom_word_packer.sv
// Four-lane byte register: writes one byte lane at a time and presents the
// lanes as a little-endian 32-bit word (lane 0 in bits [7:0]).
module rom_word_packer
    import rom_loader_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_clear,
    input  logic                      i_wr_en,
    input  logic [LANE_W-1:0]         i_lane,
    input  logic [7:0]                i_byte,
    output logic [WORD_BYTES*8-1:0]   o_word
);

    logic [WORD_BYTES-1:0][7:0] r_lanes;

    // Lane storage: clear wins over a lane write
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_lanes <= '0;
        end else if (i_wr_en) begin
            r_lanes[i_lane] <= i_byte;
        end
    end

    assign o_word = r_lanes;

endmodule

// File: rtl/rom_loader.sv
// ROM image loader: walks ROM byte addresses from 0 until rom_done, packs
// bytes into little-endian words and writes them to RAM over valid/ready.
// Optional feature: define ROM_LOADER_CHECKSUM_EN to add o_checksum, the
// modulo-2^32 sum of all accepted write words of the current load.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned MEM_AW     = 16,
    parameter int unsigned BASE_WADDR = 0,
    parameter int unsigned MAX_BYTES  = 4096
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic [31:0]       o_rom_address,
    input  logic [7:0]        i_rom_byte,
    input  logic              i_rom_done,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [MEM_AW-1:0] o_mem_waddr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_busy,
    output logic              o_finished,
    output logic              o_error,
    output logic [15:0]       o_words_loaded
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       o_checksum
`endif
);

    localparam logic [MEM_AW-1:0] BaseAddr = MEM_AW'(BASE_WADDR);
    localparam logic [31:0]       MaxAddr  = 32'(MAX_BYTES);

    state_e              r_state;
    logic [31:0]         r_rom_address;
    logic                r_mem_valid;
    logic [MEM_AW-1:0]   r_mem_waddr;
    logic                r_busy;
    logic                r_finished;
    logic                r_error;
    logic [15:0]         r_words_loaded;
    // End of image (rom_done or byte limit) already observed in this load
    logic                r_end_seen;

    logic [LANE_W-1:0]   w_lane;
    logic                w_partial;
    logic                w_at_limit;
    logic                w_start;
    logic                w_accept;
    logic                w_write_byte;
    logic                w_clear;
    logic [31:0]         w_word;

    // Lane follows the byte address because every load starts at address 0
    assign w_lane       = r_rom_address[LANE_W-1:0];
    assign w_partial    = (w_lane != '0);
    assign w_at_limit   = (r_rom_address == MaxAddr);
    assign w_start      = i_start && ((r_state == StIdle) || (r_state == StDone));
    assign w_accept     = (r_state == StWrite) && i_mem_ready;
    assign w_write_byte = (r_state == StRead) && !i_rom_done && !w_at_limit;
    assign w_clear      = w_start || w_accept;

    rom_word_packer u_packer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_clear),
        .i_wr_en (w_write_byte),
        .i_lane  (w_lane),
        .i_byte  (i_rom_byte),
        .o_word  (w_word)
    );

    // Loader FSM with address counter and write-port registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= StIdle;
            r_rom_address  <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_waddr    <= BaseAddr;
            r_busy         <= 1'b0;
            r_finished     <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= '0;
            r_end_seen     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_state        <= StRead;
                        r_rom_address  <= '0;
                        r_mem_waddr    <= BaseAddr;
                        r_words_loaded <= '0;
                        r_error        <= 1'b0;
                        r_finished     <= 1'b0;
                        r_busy         <= 1'b1;
                        r_end_seen     <= 1'b0;
                    end
                end
                StRead: begin
                    if (i_rom_done || w_at_limit) begin
                        r_end_seen <= 1'b1;
                        // rom_done has priority: an image ending exactly at the limit is not an error
                        if (!i_rom_done) begin
                            r_error <= 1'b1;
                        end
                        if (w_partial) begin
                            r_state     <= StWrite;
                            r_mem_valid <= 1'b1;
                        end else begin
                            r_state    <= StDone;
                            r_busy     <= 1'b0;
                            r_finished <= 1'b1;
                        end
                    end else begin
                        r_rom_address <= r_rom_address + 32'd1;
                        if (w_lane == LANE_W'(WORD_BYTES - 1)) begin
                            r_state     <= StWrite;
                            r_mem_valid <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (i_mem_ready) begin
                        r_mem_valid    <= 1'b0;
                        r_mem_waddr    <= r_mem_waddr + MEM_AW'(1);
                        r_words_loaded <= sat_inc16(r_words_loaded);
                        if (r_end_seen) begin
                            r_state    <= StDone;
                            r_busy     <= 1'b0;
                            r_finished <= 1'b1;
                        end else begin
                            r_state <= StRead;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    // Running sum of accepted write words
    always_ff @(posedge i_clk) begin
        if (i_reset || w_start) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + w_word;
        end
    end

    assign o_checksum = r_checksum;
`endif

    assign o_rom_address  = r_rom_address;
    assign o_mem_valid    = r_mem_valid;
    assign o_mem_waddr    = r_mem_waddr;
    assign o_mem_wdata    = w_word;
    assign o_busy         = r_busy;
    assign o_finished     = r_finished;
    assign o_error        = r_error;
    assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: a byte-array ROM, a write monitor and a
// reference model that packs the image bytes directly into expected words.
module tb_rom_loader;

    localparam int unsigned BASE   = 32'hFFF0;  // near the top so waddr wraps
    localparam int unsigned BUDGET = 5000;

    logic        clk = 1'b0;
    logic        reset, start, l_start, mem_ready;

    logic [31:0] m_rom_address, l_rom_address;
    logic [7:0]  m_rom_byte, l_rom_byte;
    logic        m_rom_done, l_rom_done;
    logic        m_valid, l_valid;
    logic [15:0] m_waddr, l_waddr;
    logic [31:0] m_wdata, l_wdata;
    logic        m_busy, m_finished, m_error, l_busy, l_finished, l_error;
    logic [15:0] m_words, l_words;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [31:0] m_checksum, l_checksum;
`endif

    logic [7:0]  rom_mem [0:4095];
    int unsigned rom_len;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          hold_err;
    int          stall_cnt;
    logic        prev_wait;
    logic [47:0] prev_w;
    logic [47:0] m_obs[$];
    logic [47:0] l_obs[$];

    always #5 clk = ~clk;

    assign m_rom_byte = (m_rom_address < 32'd4096) ? rom_mem[m_rom_address[11:0]] : 8'h00;
    assign m_rom_done = (m_rom_address == rom_len);
    assign l_rom_byte = rom_mem[l_rom_address[11:0]];
    assign l_rom_done = 1'b0;

    rom_loader #(.MEM_AW(16), .BASE_WADDR(BASE), .MAX_BYTES(4096)) u_dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .o_rom_address  (m_rom_address),
        .i_rom_byte     (m_rom_byte),
        .i_rom_done     (m_rom_done),
        .o_mem_valid    (m_valid),
        .i_mem_ready    (mem_ready),
        .o_mem_waddr    (m_waddr),
        .o_mem_wdata    (m_wdata),
        .o_busy         (m_busy),
        .o_finished     (m_finished),
        .o_error        (m_error),
        .o_words_loaded (m_words)
`ifdef ROM_LOADER_CHECKSUM_EN
        ,
        .o_checksum     (m_checksum)
`endif
    );

    rom_loader #(.MEM_AW(16), .BASE_WADDR(0), .MAX_BYTES(8)) u_dut_lim (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (l_start),
        .o_rom_address  (l_rom_address),
        .i_rom_byte     (l_rom_byte),
        .i_rom_done     (l_rom_done),
        .o_mem_valid    (l_valid),
        .i_mem_ready    (mem_ready),
        .o_mem_waddr    (l_waddr),
        .o_mem_wdata    (l_wdata),
        .o_busy         (l_busy),
        .o_finished     (l_finished),
        .o_error        (l_error),
        .o_words_loaded (l_words)
`ifdef ROM_LOADER_CHECKSUM_EN
        ,
        .o_checksum     (l_checksum)
`endif
    );

    // Mid-cycle monitor: records writes that the next rising edge will accept
    // and flags any change of a pending request before it is accepted
    always @(negedge clk) begin
        if (reset) begin
            prev_wait = 1'b0;
        end else begin
            if (prev_wait && (!m_valid || {m_waddr, m_wdata} != prev_w)) hold_err++;
            if (m_valid && mem_ready) m_obs.push_back({m_waddr, m_wdata});
            if (l_valid && mem_ready) l_obs.push_back({l_waddr, l_wdata});
            prev_wait = m_valid && !mem_ready;
            prev_w    = {m_waddr, m_wdata};
        end
    end

    // Reference: word idx of an n-byte image, missing bytes read as zero
    function automatic logic [31:0] model_word(input int unsigned idx, input int unsigned n);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            if (idx * 4 + b < n) w[b*8 +: 8] = rom_mem[idx*4 + b];
        end
        return w;
    endfunction

    function automatic int unsigned model_nwords(input int unsigned n);
        return (n + 3) / 4;
    endfunction

    // Edges after the start edge with ready always high: 5 per full word,
    // then either one READ seeing rom_done, or r reads + end read + one write
    function automatic int unsigned model_latency(input int unsigned n);
        int unsigned r;
        r = n % 4;
        return (n / 4) * 5 + ((r == 0) ? 1 : r + 2);
    endfunction

    function automatic logic [31:0] model_sum(input int unsigned n);
        logic [31:0] s;
        s = '0;
        for (int unsigned i = 0; i < model_nwords(n); i++) s += model_word(i, n);
        return s;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low 3 cycles on word 2;
    // 3: ready high plus start pulses while busy
    task automatic run_main(input int mode, output int lat);
        m_obs.delete();
        hold_err  = 0;
        stall_cnt = 0;
        mem_ready = (mode == 1) ? 1'($urandom) : 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (m_finished || lat >= BUDGET) break;
            case (mode)
                1: mem_ready = 1'($urandom);
                2: begin
                    if (m_valid && m_waddr == 16'(BASE + 2) && stall_cnt < 3) begin
                        mem_ready = 1'b0;
                        stall_cnt++;
                        n_tests++;
                        if (m_wdata !== model_word(2, rom_len)) begin
                            n_fail++;
                            $display("FAIL stall_wdata: got %h want %h", m_wdata,
                                     model_word(2, rom_len));
                        end
                    end else begin
                        mem_ready = 1'b1;
                    end
                end
                3: begin
                    mem_ready = 1'b1;
                    if (lat == 3 || lat == 5) start = 1'b1;
                end
                default: mem_ready = 1'b1;
            endcase
        end
        n_tests++;
        if (!m_finished) begin
            n_fail++;
            $display("FAIL run_timeout: finished=%b after %0d cycles, want 1", m_finished, lat);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        l_start = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got [8];
        logic [31:0] want [8];
        do_reset();
        got  = '{m_rom_address, 32'(m_valid), 32'(m_waddr), m_wdata, 32'(m_busy),
                 32'(m_finished), 32'(m_error), 32'(m_words)};
        want = '{32'd0, 32'd0, 32'(16'(BASE)), 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (got[i] !== want[i]) begin
                n_fail++;
                $display("FAIL reset_out%0d: got %h want %h", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_full_image();
        int lat;
        logic [31:0] spec_w [5];
        fill_random();
        spec_w = '{32'h1, 32'h1, 32'h5, 32'hA, 32'h10E};
        for (int i = 0; i < 20; i++) rom_mem[i] = spec_w[i/4][(i%4)*8 +: 8];
        rom_len = 196;
        run_main(0, lat);
        n_tests++;
        if (m_obs.size() != 49) begin
            n_fail++; $display("FAIL full_count: got %0d want 49", m_obs.size());
        end
        for (int i = 0; i < 5 && i < m_obs.size(); i++) begin
            n_tests++;
            if (m_obs[i][31:0] !== spec_w[i]) begin
                n_fail++; $display("FAIL full_word%0d: got %h want %h", i, m_obs[i][31:0], spec_w[i]);
            end
        end
        foreach (m_obs[i]) begin
            n_tests++;
            if (m_obs[i] !== {16'(BASE + i), model_word(i, 196)}) begin
                n_fail++;
                $display("FAIL full_write%0d: got %h want %h", i, m_obs[i],
                         {16'(BASE + i), model_word(i, 196)});
            end
        end
        n_tests++;
        if (m_words !== 16'd49) begin
            n_fail++; $display("FAIL full_words_loaded: got %0d want 49", m_words);
        end
        n_tests++;
        if (lat != model_latency(196)) begin
            n_fail++; $display("FAIL full_latency: got %0d want %0d", lat, model_latency(196));
        end
        n_tests++;
        if ({m_busy, m_error} !== 2'b00) begin
            n_fail++; $display("FAIL full_flags: busy/error got %b want 00", {m_busy, m_error});
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        n_tests++;
        if (m_checksum !== model_sum(196)) begin
            n_fail++; $display("FAIL full_checksum: got %h want %h", m_checksum, model_sum(196));
        end
`endif
    endtask

    task automatic test_stall();
        int lat;
        rom_len = 196;
        run_main(2, lat);
        n_tests++;
        if (stall_cnt != 3) begin
            n_fail++; $display("FAIL stall_seen: got %0d stalled cycles want 3", stall_cnt);
        end
        n_tests++;
        if (hold_err != 0) begin
            n_fail++; $display("FAIL stall_hold: got %0d changes while waiting want 0", hold_err);
        end
        n_tests++;
        if (m_obs.size() != 49 || m_words !== 16'd49) begin
            n_fail++;
            $display("FAIL stall_count: got %0d/%0d want 49", m_obs.size(), m_words);
        end
        foreach (m_obs[i]) begin
            n_tests++;
            if (m_obs[i] !== {16'(BASE + i), model_word(i, 196)}) begin
                n_fail++; $display("FAIL stall_write%0d: got %h", i, m_obs[i]);
            end
        end
    endtask

    task automatic test_short_image();
        int lat;
        for (int i = 0; i < 6; i++) rom_mem[i] = 8'h11 + 8'(i);
        rom_len = 6;
        run_main(3, lat);  // includes start pulses while busy
        n_tests++;
        if (m_obs.size() != 2) begin
            n_fail++; $display("FAIL short_count: got %0d want 2", m_obs.size());
        end else begin
            n_tests++;
            if (m_obs[0] !== {16'(BASE), 32'h14131211}) begin
                n_fail++; $display("FAIL short_word0: got %h want %h", m_obs[0], {16'(BASE), 32'h14131211});
            end
            n_tests++;
            if (m_obs[1] !== {16'(BASE + 1), 32'h00001615}) begin
                n_fail++; $display("FAIL short_word1: got %h want %h", m_obs[1], {16'(BASE + 1), 32'h00001615});
            end
        end
        n_tests++;
        if (m_words !== 16'd2) begin
            n_fail++; $display("FAIL short_words_loaded: got %0d want 2", m_words);
        end
        n_tests++;
        if (lat != model_latency(6)) begin
            n_fail++; $display("FAIL short_latency: got %0d want %0d", lat, model_latency(6));
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        n_tests++;
        if (m_checksum !== 32'h14132826) begin
            n_fail++; $display("FAIL short_checksum: got %h want 14132826", m_checksum);
        end
`endif
    endtask

    task automatic test_limit();
        int cyc;
        fill_random();
        l_obs.delete();
        mem_ready = 1'b1;
        l_start = 1'b1;
        @(posedge clk); #1;
        l_start = 1'b0;
        cyc = 0;
        while (!l_finished && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++;
        if (l_obs.size() != 2) begin
            n_fail++; $display("FAIL limit_count: got %0d want 2", l_obs.size());
        end
        foreach (l_obs[i]) begin
            n_tests++;
            if (l_obs[i] !== {16'(i), model_word(i, 8)}) begin
                n_fail++; $display("FAIL limit_write%0d: got %h want %h", i, l_obs[i], {16'(i), model_word(i, 8)});
            end
        end
        n_tests++;
        if ({l_error, l_finished, l_busy} !== 3'b110 || l_words !== 16'd2) begin
            n_fail++;
            $display("FAIL limit_flags: err/fin/busy got %b words %0d want 110 words 2",
                     {l_error, l_finished, l_busy}, l_words);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int lat;
        fill_random();
        rom_len = 196;
        mem_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(m_valid && m_waddr == 16'(BASE + 3)) && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++;
        if (!m_valid) begin
            n_fail++; $display("FAIL midreset_reach: valid got %b want 1", m_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({m_rom_address, m_valid, m_waddr, m_wdata, m_busy, m_finished, m_error, m_words}
            !== {32'd0, 1'b0, 16'(BASE), 32'd0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL midreset_out: addr %h valid %b waddr %h wdata %h busy %b fin %b err %b words %0d",
                     m_rom_address, m_valid, m_waddr, m_wdata, m_busy, m_finished, m_error, m_words);
        end
        reset = 1'b0;
        run_main(0, lat);
        n_tests++;
        if (m_obs.size() != 49) begin
            n_fail++; $display("FAIL midreset_count: got %0d want 49", m_obs.size());
        end
        foreach (m_obs[i]) begin
            n_tests++;
            if (m_obs[i] !== {16'(BASE + i), model_word(i, 196)}) begin
                n_fail++; $display("FAIL midreset_write%0d: got %h", i, m_obs[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int unsigned n;
        for (int it = 0; it < 8; it++) begin
            fill_random();
            n = $urandom_range(1, 60);
            rom_len = n;
            run_main(it % 2, lat);
            n_tests++;
            if (m_obs.size() != model_nwords(n) || m_words !== 16'(model_nwords(n))) begin
                n_fail++;
                $display("FAIL b2b%0d_count: got %0d/%0d want %0d", it, m_obs.size(), m_words,
                         model_nwords(n));
            end
            foreach (m_obs[i]) begin
                n_tests++;
                if (m_obs[i] !== {16'(BASE + i), model_word(i, n)}) begin
                    n_fail++;
                    $display("FAIL b2b%0d_write%0d: got %h want %h", it, i, m_obs[i],
                             {16'(BASE + i), model_word(i, n)});
                end
            end
            n_tests++;
            if (hold_err != 0 || m_error !== 1'b0) begin
                n_fail++; $display("FAIL b2b%0d_hold: changes %0d err %b want 0 0", it, hold_err, m_error);
            end
            if (it % 2 == 0) begin
                n_tests++;
                if (lat != model_latency(n)) begin
                    n_fail++; $display("FAIL b2b%0d_latency: got %0d want %0d", it, lat, model_latency(n));
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            n_tests++;
            if (m_checksum !== model_sum(n)) begin
                n_fail++; $display("FAIL b2b%0d_checksum: got %h want %h", it, m_checksum, model_sum(n));
            end
`endif
        end
    endtask

    initial begin
        rom_len = 196;
        hold_err = 0;
        prev_wait = 1'b0;
        prev_w = '0;
        test_reset();
        test_full_image();
        test_stall();
        test_short_image();
        test_limit();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
